// File: rtl/uart_receiver.sv
// UART 8N1 receiver: two-flop synchroniser, mid-bit sampling, LSB-first byte
// reassembly with stop-bit check, one-cycle rx_valid / frame_err strobes.
module uart_receiver #(
    parameter int BAUD_RATE = 9600,
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_DIV  = CLK_FREQ / BAUD_RATE,
    parameter int HALF_DIV  = BAUD_DIV / 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic [2:0]    rx_pipe;
    logic [1:0]    warm;
    logic          rx_s;
    logic          rx_d;

    assign rx_s = rx_pipe[1];
    assign rx_d = rx_pipe[2];

    always_ff @(posedge clk) begin
        if (!reset_n) rx_pipe <= 3'b111;
        else          rx_pipe <= {rx_pipe[1:0], rx};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= 4'd0;
            shift_reg <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            warm      <= 2'd0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            // Synchroniser resets high; ignore edges until real line values reach rx_d,
            // so a line held low out of reset never looks like a start bit.
            if (warm != 2'd3) warm <= warm + 2'd1;
            case (state)
                IDLE: begin
                    if (warm == 2'd3 && rx_d && !rx_s) begin
                        state    <= START;
                        baud_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= 4'd0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt  <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) state <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                        if (rx_s) begin
                            rx_data  <= shift_reg;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
